fetch_unit: RTL

- Instruction fetch front-end sitting directly upstream of the 8-bit RISC datapath.
- Owns the fetch PC and drives a synchronous instruction memory (1-cycle read latency).
- Buffers fetched instructions in a small prefetch FIFO and presents them to the datapath over a valid/ready handshake.
- Supports branch/jump redirect with flush of buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_unit_if.sv | 36 +++
 rtl/fetch_unit_sync_fifo.sv | 86 ++++++++
 rtl/fetch_unit.sv | 101 ++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front-end.
//   ADDR_W / DATA_W : fetch PC width and instruction width
//   DEF_DEPTH       : default prefetch FIFO depth
//   DEF_RESET_PC    : default first fetch address after reset
//   fetch_entry_t   : one buffered instruction together with its PC
package fetch_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int DEF_DEPTH = 4;
  localparam logic [ADDR_W-1:0] DEF_RESET_PC = 8'h00;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, its instruction memory and the datapath.
//   imem_req/imem_addr/imem_rdata : synchronous instruction memory port
//   redirect_valid/redirect_pc     : PC redirect from the datapath
//   instr_valid/instr/instr_pc/instr_ready : instruction handshake
//   fifo_count                     : prefetch FIFO occupancy
// master = fetch unit side, slave = memory/datapath side.
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, fifo_count,
    input  imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, fifo_count,
    output imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_unit_sync_fifo.sv
// Generic DEPTH-entry FIFO of fetch_entry_t with push, pop and flush.
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush_i        : clears the FIFO; wins over push and pop
//   push_i/push_data_i : write an entry (dropped when full)
//   pop_i          : drop the head entry (ignored when empty)
//   head_o         : head entry, all zeros when empty
//   count_o        : current occupancy
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push_i & (count_q != CNT_W'(DEPTH));
  assign do_pop_s  = pop_i & (count_q != CNT_W'(0));

  // Next-state pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer, occupancy and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (!flush_i && do_push_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

  assign head_o  = (count_q != CNT_W'(0)) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, issues reads to a 1-cycle
// synchronous instruction memory, buffers responses in a prefetch FIFO and
// hands them to the datapath over valid/ready. A redirect flushes buffered
// and in-flight fetches and restarts fetching at the new target.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : fetch_unit_if master (imem port, redirect, instr handshake, fifo_count)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              run_q;
  logic              inflight_q, inflight_d;
  logic              squash_q, squash_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;

  logic [CNT_W-1:0]  count_s;
  logic [CNT_W-1:0]  credit_s;
  logic              req_s;
  logic              push_s;
  logic              pop_s;
  fetch_entry_t      push_entry_s;
  fetch_entry_t      head_s;

  // Entries held plus the one response still on its way must leave a free slot.
  assign credit_s = count_s + CNT_W'(inflight_q);
  assign req_s    = run_q & ~bus.redirect_valid & (credit_s < CNT_W'(DEPTH));

  // The response lands in the cycle after its request; a redirect or a
  // pending squash makes it stale.
  assign push_s       = inflight_q & ~squash_q & ~bus.redirect_valid;
  assign pop_s        = (count_s != CNT_W'(0)) & bus.instr_ready & ~bus.redirect_valid;
  assign push_entry_s = '{pc: req_pc_q, instr: bus.imem_rdata};

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .flush_i     (bus.redirect_valid),
    .push_i      (push_s),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .count_o     (count_s)
  );

  // PC / credit / squash next state; redirect outranks any request.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    squash_d   = 1'b0;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
      inflight_d = 1'b0;
      squash_d   = inflight_q;
    end else if (req_s) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      req_pc_d   = fetch_pc_q;
      inflight_d = 1'b1;
    end else begin
      inflight_d = 1'b0;
    end
  end

  // Fetch control registers; run enables requests from the first edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  assign bus.imem_req    = req_s;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = (count_s != CNT_W'(0));
  assign bus.instr       = head_s.instr;
  assign bus.instr_pc    = head_s.pc;
  assign bus.fifo_count  = count_s;

endmodule
